// File: rtl/bip_pkg.sv
// Shared opcode, accumulator-mux and FSM state encodings for the BIP sequencer
// and its arithmetic unit.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: RAM read request in the decode phase,
// datapath strobes and mux selects in the execute phase only.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int N_OP = 5
) (
    input  logic [N_OP-1:0] op,
    input  logic            dec,
    input  logic            exec,
    output logic [1:0]      sel_a,
    output logic            sel_b,
    output logic            wr_acc,
    output logic            wr_ram,
    output logic            rd_ram,
    output logic [N_OP-1:0] alu_op,
    output logic            illegal
);

    always_comb begin
        sel_a   = SELA_RAM;
        sel_b   = 1'b0;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;
        alu_op  = '0;
        illegal = 1'b0;

        // RAM data must be ready by EXEC, so the read is issued one cycle early
        if (dec) begin
            case (op)
                OP_LD, OP_ADD, OP_SUB: rd_ram = 1'b1;
                default: rd_ram = 1'b0;
            endcase
        end

        if (exec) begin
            case (op)
                OP_HLT: begin end
                OP_STO: wr_ram = 1'b1;
                OP_LD: begin
                    wr_acc = 1'b1;
                    sel_a  = SELA_RAM;
                end
                OP_LDI: begin
                    wr_acc = 1'b1;
                    sel_a  = SELA_IMM;
                end
                OP_ADD, OP_SUB: begin
                    wr_acc = 1'b1;
                    sel_a  = SELA_ALU;
                    alu_op = op;
                end
                OP_ADDI, OP_SUBI: begin
                    wr_acc = 1'b1;
                    sel_a  = SELA_ALU;
                    sel_b  = 1'b1;
                    alu_op = op;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/bip_control.sv
// BIP instruction sequencer: FETCH/DECODE/EXEC FSM, program counter,
// instruction register and debug cycle counter.
module bip_control
    import bip_pkg::*;
#(
    parameter int N_BUS  = 16,
    parameter int N_OP   = 5,
    parameter int N_ADDR = 11,
    parameter int N_CYC  = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_START,
    input  logic [N_BUS-1:0]  i_INSTR,
    output logic [N_ADDR-1:0] o_PROG_ADDR,
    output logic [N_OP-1:0]   o_OP,
    output logic [1:0]        o_SEL_A,
    output logic              o_SEL_B,
    output logic [N_BUS-1:0]  o_IMM,
    output logic [N_ADDR-1:0] o_DATA_ADDR,
    output logic              o_RD_RAM,
    output logic              o_WR_RAM,
    output logic              o_WR_ACC,
    output logic              o_HALT,
    output logic              o_ILLEGAL,
    output logic [N_CYC-1:0]  o_CYCLES
);

    state_t            state, state_nxt;
    logic [N_ADDR-1:0] pc, pc_nxt;
    logic [N_BUS-1:0]  ir;
    logic [N_CYC-1:0]  cycles;
    logic              clr_cyc;
    logic              dec_ph, exec_ph, run_ph;
    logic [N_BUS-1:0]  cur;

    assign dec_ph  = (state == ST_DECODE);
    assign exec_ph = (state == ST_EXEC);
    assign run_ph  = (state == ST_FETCH) || dec_ph || exec_ph;

    // During DECODE the word is still on the memory bus, not yet in IR
    assign cur = dec_ph ? i_INSTR : ir;

    bip_decoder #(.N_OP(N_OP)) u_dec (
        .op      (cur[N_BUS-1 -: N_OP]),
        .dec     (dec_ph),
        .exec    (exec_ph),
        .sel_a   (o_SEL_A),
        .sel_b   (o_SEL_B),
        .wr_acc  (o_WR_ACC),
        .wr_ram  (o_WR_RAM),
        .rd_ram  (o_RD_RAM),
        .alu_op  (o_OP),
        .illegal (o_ILLEGAL)
    );

    assign o_PROG_ADDR = pc;
    assign o_DATA_ADDR = cur[N_ADDR-1:0];
    assign o_IMM       = {{(N_BUS-N_ADDR){ir[N_ADDR-1]}}, ir[N_ADDR-1:0]};
    assign o_HALT      = (state == ST_HALT);
    assign o_CYCLES    = cycles;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        clr_cyc   = 1'b0;
        case (state)
            ST_IDLE:   if (i_START) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (ir[N_BUS-1 -: N_OP] == OP_HLT) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = pc + N_ADDR'(1);
                end
            end
            ST_HALT: begin
                if (i_START) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                    clr_cyc   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            cycles <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (dec_ph)
                ir <= i_INSTR;
            if (clr_cyc)
                cycles <= '0;
            else if (run_ph && (cycles != {N_CYC{1'b1}}))
                cycles <= cycles + N_CYC'(1);
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed programs plus randomized
// programs checked against an instruction-level reference model.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr;
    logic [10:0] prog_addr;
    logic [4:0]  op;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [15:0] imm;
    logic [10:0] data_addr;
    logic        rd_ram, wr_ram, wr_acc, halt, illegal;
    logic [31:0] cycles;

    logic [15:0] mem [0:2047];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] m_pc;
    logic [31:0] m_cyc;

    bip_control dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_START     (start),
        .i_INSTR     (instr),
        .o_PROG_ADDR (prog_addr),
        .o_OP        (op),
        .o_SEL_A     (sel_a),
        .o_SEL_B     (sel_b),
        .o_IMM       (imm),
        .o_DATA_ADDR (data_addr),
        .o_RD_RAM    (rd_ram),
        .o_WR_RAM    (wr_ram),
        .o_WR_ACC    (wr_acc),
        .o_HALT      (halt),
        .o_ILLEGAL   (illegal),
        .o_CYCLES    (cycles)
    );

    always #5 clk = ~clk;

    // synchronous-read program memory
    always @(posedge clk) instr <= mem[prog_addr];

    function automatic logic [15:0] mk(input int opc, input int opnd);
        logic [4:0]  o = 5'(opc);
        logic [10:0] a = 11'(opnd);
        return {o, a};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // expected {wr_acc,wr_ram,rd_ram,sel_a,sel_b,op,illegal,imm,data_addr} in EXEC
    function automatic logic [38:0] exp_exec(input logic [15:0] ins);
        int          opc = int'(ins[15:11]);
        logic        wa = 1'b0, wr = 1'b0, sb = 1'b0, il = 1'b0;
        logic [1:0]  sa = 2'd0;
        logic [4:0]  o = 5'd0;
        logic [15:0] sx = {{5{ins[10]}}, ins[10:0]};
        case (opc)
            0: ;
            1: wr = 1'b1;
            2: wa = 1'b1;
            3: begin wa = 1'b1; sa = 2'd1; end
            4, 6: begin wa = 1'b1; sa = 2'd2; o = ins[15:11]; end
            5, 7: begin wa = 1'b1; sa = 2'd2; sb = 1'b1; o = ins[15:11]; end
            default: il = 1'b1;
        endcase
        return {wa, wr, 1'b0, sa, sb, o, il, sx, ins[10:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) mem[i] = w;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_pc  = '0;
        m_cyc = '0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered with the DUT in FETCH; walks up to max_instr instructions.
    task automatic run_check(input int max_instr, input bit rnd_start);
        for (int k = 0; k < max_instr; k++) begin
            logic [15:0] ins;
            logic [4:0]  opc;
            logic        rd;
            logic [38:0] ac;
            logic [38:0] ex;
            n_tests++;
            if ({prog_addr, cycles, halt, wr_acc, wr_ram, rd_ram, illegal, op} !==
                {m_pc, m_cyc, 5'b0, 5'b0}) begin
                n_fail++;
                $display("FAIL fetch k=%0d pc=%h/%h cyc=%0d/%0d strobes=%b%b%b%b%b op=%h",
                         k, prog_addr, m_pc, cycles, m_cyc, halt, wr_acc, wr_ram, rd_ram, illegal, op);
            end
            if (rnd_start) start = 1'($urandom_range(0, 1));
            step();
            m_cyc = sat_inc(m_cyc);

            ins = mem[m_pc];
            opc = ins[15:11];
            rd  = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
            n_tests++;
            if ({rd_ram, data_addr, wr_acc, wr_ram, op, illegal} !== {rd, ins[10:0], 8'b0}) begin
                n_fail++;
                $display("FAIL decode pc=%h rd=%b/%b daddr=%h/%h wr=%b%b op=%h ill=%b",
                         m_pc, rd_ram, rd, data_addr, ins[10:0], wr_acc, wr_ram, op, illegal);
            end
            if (rnd_start) start = 1'($urandom_range(0, 1));
            step();
            m_cyc = sat_inc(m_cyc);

            ex = exp_exec(ins);
            ac = {wr_acc, wr_ram, rd_ram, sel_a, sel_b, op, illegal, imm, data_addr};
            n_tests++;
            if (ac !== ex) begin
                n_fail++;
                $display("FAIL exec pc=%h instr=%h got=%h expected=%h", m_pc, ins, ac, ex);
            end
            if (rnd_start) start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            m_cyc = sat_inc(m_cyc);

            if (opc == 5'd0) begin
                n_tests++;
                if ({halt, prog_addr, cycles, wr_acc, wr_ram, illegal} !== {1'b1, m_pc, m_cyc, 3'b0}) begin
                    n_fail++;
                    $display("FAIL halt_entry halt=%b pc=%h/%h cyc=%0d/%0d",
                             halt, prog_addr, m_pc, cycles, m_cyc);
                end
                return;
            end
            m_pc = m_pc + 11'd1;
        end
    endtask

    task automatic test_reset();
        fill(16'h0000);
        do_reset();
        n_tests++;
        if ({prog_addr, op, sel_a, sel_b, imm, data_addr, rd_ram, wr_ram, wr_acc, halt, illegal, cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_state pc=%h op=%h sa=%b sb=%b imm=%h da=%h str=%b%b%b%b%b cyc=%0d",
                     prog_addr, op, sel_a, sel_b, imm, data_addr, rd_ram, wr_ram, wr_acc, halt, illegal, cycles);
        end
        repeat (3) step();
        n_tests++;
        if ({prog_addr, cycles, halt, rd_ram} !== '0) begin
            n_fail++;
            $display("FAIL idle_hold pc=%h cyc=%0d halt=%b", prog_addr, cycles, halt);
        end
    endtask

    task automatic test_basic();
        fill(16'h0000);
        mem[0] = mk(3, 5);
        mem[1] = mk(5, 3);
        mem[2] = mk(1, 'h010);
        mem[3] = mk(0, 0);
        do_reset();
        start_run();
        run_check(10, 1'b0);
        n_tests++;
        if (halt !== 1'b1 || prog_addr !== 11'd3 || cycles !== 32'd12) begin
            n_fail++;
            $display("FAIL basic_halt halt=%b pc=%h cyc=%0d expected 1/003/12", halt, prog_addr, cycles);
        end
    endtask

    task automatic test_restart();
        repeat (3) step();
        n_tests++;
        if (halt !== 1'b1 || prog_addr !== 11'd3 || cycles !== 32'd12) begin
            n_fail++;
            $display("FAIL halt_frozen halt=%b pc=%h cyc=%0d", halt, prog_addr, cycles);
        end
        start_run();
        n_tests++;
        if (halt !== 1'b0 || prog_addr !== 11'd0 || cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL restart halt=%b pc=%h cyc=%0d expected 0/000/0", halt, prog_addr, cycles);
        end
        m_pc  = '0;
        m_cyc = '0;
        run_check(10, 1'b0);
    endtask

    task automatic test_ld_sub();
        fill(16'h0000);
        mem[0] = mk(2, 'h020);
        mem[1] = mk(6, 'h021);
        mem[2] = mk(7, 'h7FF);
        mem[3] = mk(0, 0);
        do_reset();
        start_run();
        run_check(10, 1'b0);
    endtask

    task automatic test_illegal();
        fill(16'h0000);
        mem[0] = mk('b01010, 'h123);
        do_reset();
        start_run();
        run_check(3, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2048; i++) mem[i] = mk($urandom_range(8, 31), $urandom_range(0, 2047));
        do_reset();
        start_run();
        run_check(2048, 1'b0);
        n_tests++;
        if (prog_addr !== 11'h000) begin
            n_fail++;
            $display("FAIL pc_wrap pc=%h expected 000", prog_addr);
        end
    endtask

    task automatic test_reset_mid();
        fill(16'h0000);
        mem[0] = mk(1, 'h055);
        do_reset();
        start_run();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (wr_ram !== 1'b1 || data_addr !== 11'h055) begin
            n_fail++;
            $display("FAIL sto_exec wr_ram=%b da=%h expected 1/055", wr_ram, data_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wr_ram, wr_acc, prog_addr, halt, cycles} !== '0) begin
            n_fail++;
            $display("FAIL async_reset wr=%b%b pc=%h halt=%b cyc=%0d", wr_ram, wr_acc, prog_addr, halt, cycles);
        end
        step();
        rst_n = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({prog_addr, cycles, rd_ram, wr_ram, halt} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset pc=%h cyc=%0d", prog_addr, cycles);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(8, 40);
            fill(16'h0000);
            for (int i = 0; i < n - 1; i++) begin
                int opc = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 7) : $urandom_range(8, 31);
                mem[i] = mk(opc, $urandom_range(0, 2047));
            end
            do_reset();
            start_run();
            run_check(n + 1, 1'b1);
            n_tests++;
            if (halt !== 1'b1 || prog_addr !== 11'(n - 1)) begin
                n_fail++;
                $display("FAIL rand_halt r=%0d halt=%b pc=%h expected %h", r, halt, prog_addr, 11'(n - 1));
            end
            if (r == 0) begin
                start_run();
                m_pc  = '0;
                m_cyc = '0;
                run_check(n + 1, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_ld_sub();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
Instruction sequencer for the accumulator (BIP) processor. It owns the program counter, fetches 16-bit instructions from a synchronous-read program memory, and decodes them. It drives the data-memory strobes, the accumulator input mux and the opcode fed to the arithmetic unit. A start/halt handshake and a cycle counter are provided for the debug unit.

Parameters:
N_BUS, 16, instruction/data width
N_OP, 5, opcode width (instr[N_BUS-1 -: N_OP])
N_ADDR, 11, program/data address width (instr[N_ADDR-1:0] = operand)
N_CYC, 32, cycle counter width

Ports:
i_CLK  in  1  clock, rising edge
i_RST_N  in  1  asynchronous active-low reset
i_START  in  1  start pulse; accepted only in IDLE or HALT
i_INSTR  in  N_BUS  program memory read data (valid 1 cycle after o_PROG_ADDR)
o_PROG_ADDR  out  N_ADDR  program memory address = PC
o_OP  out  N_OP  opcode to arithmetic unit
o_SEL_A  out  2  ACC input mux: 00 data RAM, 01 immediate, 10 ALU result
o_SEL_B  out  1  ALU operand: 0 data RAM, 1 immediate
o_IMM  out  N_BUS  operand sign-extended to N_BUS
o_DATA_ADDR  out  N_ADDR  data RAM address = operand
o_RD_RAM  out  1  data RAM read enable
o_WR_RAM  out  1  data RAM write enable (write data = ACC)
o_WR_ACC  out  1  accumulator load enable
o_HALT  out  1  high in HALT
o_ILLEGAL  out  1  one-cycle pulse on an undefined opcode
o_CYCLES  out  N_CYC  cycles spent in FETCH/DECODE/EXEC

Behaviour:
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111; 01000..11111 are illegal.
- Reset (async, i_RST_N=0):
  - state=IDLE, PC=0, instruction register=0, o_CYCLES=0.
  - All strobes 0, o_SEL_A=00, o_SEL_B=0, o_OP=0, o_HALT=0, o_ILLEGAL=0.
  - Reset mid-instruction aborts with no strobe emitted.
- FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH, with HALT as a terminal state.
  - IDLE: outputs inactive. i_START -> FETCH.
  - FETCH: o_PROG_ADDR=PC. Next cycle -> DECODE.
  - DECODE: latch i_INSTR into IR. o_DATA_ADDR=operand. o_RD_RAM=1 for LD/ADD/SUB only. -> EXEC.
  - EXEC: decode IR; the strobes are valid this cycle only.
    - STO: o_WR_RAM=1.
    - LD: o_WR_ACC=1, SEL_A=00.
    - LDI: o_WR_ACC=1, SEL_A=01.
    - ADD/SUB: o_WR_ACC=1, SEL_A=10, SEL_B=0, o_OP=opcode.
    - ADDI/SUBI: as ADD/SUB but SEL_B=1.
    - HLT: no strobes, PC unchanged -> HALT.
    - Illegal: no strobes, o_ILLEGAL=1, PC+1 (behaves as NOP).
    - Every non-HLT instruction: PC<=PC+1 at the end of EXEC, then -> FETCH.
  - HALT: o_HALT=1, PC frozen, o_CYCLES frozen. i_START -> FETCH with PC reset to 0 and o_CYCLES cleared.
- Timing: 3 cycles per instruction.
- o_OP is 0 outside EXEC of arithmetic instructions, so the arithmetic unit outputs 0 when unused.
- Control outputs are combinational from state+IR; IR is stable from the cycle after DECODE.
- Output values outside EXEC: o_IMM and o_DATA_ADDR follow IR. o_PROG_ADDR=PC in all states.
- PC wraps from 2^N_ADDR-1 to 0 with no flag.
- o_CYCLES increments every cycle in FETCH/DECODE/EXEC and saturates at all-ones.
- i_START is ignored in FETCH/DECODE/EXEC.
- Immediate: o_IMM = {{(N_BUS-N_ADDR){instr[N_ADDR-1]}}, instr[N_ADDR-1:0]}.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams OP_HLT..OP_SUBI, matching the codes the arithmetic unit uses;
  - SEL_A encodings SELA_RAM/SELA_IMM/SELA_ALU;
  - state encodings.
- One natural sub-module: bip_decoder, purely combinational, mapping opcode plus an exec flag to {SEL_A, SEL_B, WR_ACC, WR_RAM, RD_RAM, OP, ILLEGAL}.
- bip_control keeps the FSM, PC, IR and cycle counter.

Test Plan:
- Reset, then i_START, with program LDI 5; ADDI 3; STO 0x010; HLT -> exact sequence of o_PROG_ADDR, strobes and SEL values:
  - EXEC1: WR_ACC=1, SEL_A=01, IMM=5.
  - EXEC2: OP=00101, SEL_B=1, SEL_A=10.
  - EXEC3: WR_RAM=1, DATA_ADDR=0x010.
  - Then o_HALT=1, PC=3, o_CYCLES=12.
- LD 0x020; SUB 0x021; HLT -> RD_RAM=1 in DECODE of both; EXEC2 OP=00110, SEL_B=0; SUBI with operand 0x7FF gives o_IMM=0xFFFF.
- Opcode 01010 at PC 0 -> o_ILLEGAL pulses 1 cycle, no WR strobes, next fetch address 1.
- PC wrap: preload NOPs (illegal opcodes) to address 0x7FF -> after its EXEC, o_PROG_ADDR=0x000.
- Assert i_RST_N=0 during EXEC of STO -> o_WR_RAM drops immediately, state IDLE, PC=0; i_START while in DECODE -> ignored.
- From HALT, i_START -> o_HALT=0 next cycle, PC=0, o_CYCLES restarts from 0.
